// File: rtl/register_scoreboard.sv
// register_scoreboard
// Issue-control scoreboard for a dual-issue pair feeding the register file.
// Each register carries a small countdown of cycles until its pending write
// lands; a nonzero count marks the register busy. Two candidate instructions
// (slot 1 older, slot 2 younger) are granted in the same cycle they are
// presented, subject to RAW/WAW checks against busy registers, an intra-pair
// dependency check, and in-order issue.
module register_scoreboard #(
    parameter int NUM_REGS = 128,
    parameter int ADDR_W   = 7,
    parameter int LAT_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,

    input  logic                valid1,
    input  logic [ADDR_W-1:0]   ra1,
    input  logic [ADDR_W-1:0]   rb1,
    input  logic [ADDR_W-1:0]   rc1,
    input  logic                use_ra1,
    input  logic                use_rb1,
    input  logic                use_rc1,
    input  logic [ADDR_W-1:0]   rt1,
    input  logic                wr_rt1,
    input  logic [LAT_W-1:0]    lat1,

    input  logic                valid2,
    input  logic [ADDR_W-1:0]   ra2,
    input  logic [ADDR_W-1:0]   rb2,
    input  logic [ADDR_W-1:0]   rc2,
    input  logic                use_ra2,
    input  logic                use_rb2,
    input  logic                use_rc2,
    input  logic [ADDR_W-1:0]   rt2,
    input  logic                wr_rt2,
    input  logic [LAT_W-1:0]    lat2,

    output logic                issue1,
    output logic                issue2,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy
);

    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    // Remaining cycles until each register's outstanding write completes.
    logic [LAT_W-1:0] cnt [NUM_REGS];

    logic             hz1;
    logic             hz2;
    logic             intra;
    logic [LAT_W-1:0] lat1_eff;
    logic [LAT_W-1:0] lat2_eff;

    // A register is busy while its countdown is nonzero.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

    // Hazard detection, same-cycle grants and stall indication.
    always_comb begin
        // NOTE: every output gets a default at the top so no path leaves one
        // unassigned, which would otherwise infer a latch.
        hz1      = 1'b0;
        hz2      = 1'b0;
        intra    = 1'b0;
        issue1   = 1'b0;
        issue2   = 1'b0;
        stall    = 1'b0;

        hz1 = (use_ra1 & busy[ra1]) | (use_rb1 & busy[rb1]) |
              (use_rc1 & busy[rc1]) | (wr_rt1 & busy[rt1]);

        // Slot 2 may not read or overwrite what the older slot is writing.
        intra = valid1 & wr_rt1 &
                ((use_ra2 & (ra2 == rt1)) | (use_rb2 & (rb2 == rt1)) |
                 (use_rc2 & (rc2 == rt1)) | (wr_rt2  & (rt2 == rt1)));

        hz2 = (use_ra2 & busy[ra2]) | (use_rb2 & busy[rb2]) |
              (use_rc2 & busy[rc2]) | (wr_rt2 & busy[rt2]) | intra;

        issue1 = valid1 & ~hz1 & ~flush & ~reset;
        // Slot 2 never overtakes a held slot 1.
        issue2 = valid2 & ~hz2 & ~flush & ~reset & (issue1 | ~valid1);
        stall  = ~reset & ((valid1 & ~issue1) | (valid2 & ~issue2));
    end

    // A latency of zero still occupies the register for one cycle.
    always_comb begin
        lat1_eff = (lat1 == '0) ? LAT_ONE : lat1;
        lat2_eff = (lat2 == '0) ? LAT_ONE : lat2;
    end

    // Load a countdown for each newly issued write, otherwise count down;
    // reset and flush discard all pending writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            // NOTE: state uses non-blocking assignments so every countdown
            // updates from the same pre-edge values; the array is plain flops
            // (not a RAM) and must be cleared, so it is reset element-wise.
            if (reset || flush) begin
                cnt[i] <= '0;
            end else if (issue1 && wr_rt1 && (rt1 == ADDR_W'(i))) begin
                cnt[i] <= lat1_eff;
            end else if (issue2 && wr_rt2 && (rt2 == ADDR_W'(i))) begin
                cnt[i] <= lat2_eff;
            end else if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - LAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard
// Table-driven checks of the pair-issue rules from a clean state, hand-written
// multi-cycle sequences for latency, in-order and flush behaviour, and a
// randomized run compared against a release-time model of register busyness.
module tb_register_scoreboard;

    localparam int NUM_REGS = 128;

    typedef struct packed {
        logic       v;
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic       ua;
        logic       ub;
        logic       uc;
        logic [6:0] rt;
        logic       w;
        logic [2:0] lat;
    } slot_t;

    typedef struct {
        slot_t s1;
        slot_t s2;
        logic  f;
        logic  r;
        logic  e1;
        logic  e2;
        logic  es;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset_i;
    logic                flush_i;
    slot_t               s1;
    slot_t               s2;
    logic                issue1;
    logic                issue2;
    logic                stall;
    logic [NUM_REGS-1:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    register_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(7), .LAT_W(3)) dut (
        .clk     (clk),
        .reset   (reset_i),
        .flush   (flush_i),
        .valid1  (s1.v),
        .ra1     (s1.ra),
        .rb1     (s1.rb),
        .rc1     (s1.rc),
        .use_ra1 (s1.ua),
        .use_rb1 (s1.ub),
        .use_rc1 (s1.uc),
        .rt1     (s1.rt),
        .wr_rt1  (s1.w),
        .lat1    (s1.lat),
        .valid2  (s2.v),
        .ra2     (s2.ra),
        .rb2     (s2.rb),
        .rc2     (s2.rc),
        .use_ra2 (s2.ua),
        .use_rb2 (s2.ub),
        .use_rc2 (s2.uc),
        .rt2     (s2.rt),
        .wr_rt2  (s2.w),
        .lat2    (s2.lat),
        .issue1  (issue1),
        .issue2  (issue2),
        .stall   (stall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic slot_t mk(int v, int ra, int ua, int rb, int ub,
                                 int rc, int uc, int rt, int w, int lat);
        slot_t s;
        s.v   = 1'(v);
        s.ra  = 7'(ra);
        s.ua  = 1'(ua);
        s.rb  = 7'(rb);
        s.ub  = 1'(ub);
        s.rc  = 7'(rc);
        s.uc  = 1'(uc);
        s.rt  = 7'(rt);
        s.w   = 1'(w);
        s.lat = 3'(lat);
        return s;
    endfunction

    function automatic slot_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t mv(slot_t a, slot_t b, int f, int r,
                                int e1, int e2, int es);
        vec_t t;
        t.s1 = a;
        t.s2 = b;
        t.f  = 1'(f);
        t.r  = 1'(r);
        t.e1 = 1'(e1);
        t.e2 = 1'(e2);
        t.es = 1'(es);
        return t;
    endfunction

    function automatic logic [NUM_REGS-1:0] bit_of(int i);
        logic [NUM_REGS-1:0] b;
        b    = '0;
        b[i] = 1'b1;
        return b;
    endfunction

    task automatic check1(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkv(string name, logic [NUM_REGS-1:0] act,
                          logic [NUM_REGS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(slot_t a, slot_t b, logic f, logic r);
        s1      = a;
        s2      = b;
        flush_i = f;
        reset_i = r;
    endtask

    // Check the current cycle at the falling edge, then advance past the
    // next rising edge.
    task automatic expect_cyc(string n, logic e1, logic e2, logic es,
                              logic [NUM_REGS-1:0] eb);
        @(negedge clk);
        check1({n, "_issue1"}, issue1, e1);
        check1({n, "_issue2"}, issue2, e2);
        check1({n, "_stall"},  stall,  es);
        checkv({n, "_busy"},   busy,   eb);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(idle(), idle(), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Reference: a register written at cycle T with latency L is busy
    // through cycle T + max(L,1); release times are absolute cycle numbers.
    int until_c [NUM_REGS];

    function automatic logic src_hazard(slot_t s, logic [NUM_REGS-1:0] mb);
        return (s.ua && mb[s.ra]) || (s.ub && mb[s.rb]) ||
               (s.uc && mb[s.rc]) || (s.w && mb[s.rt]);
    endfunction

    function automatic logic touches(slot_t s, logic [6:0] r);
        return (s.ua && s.ra == r) || (s.ub && s.rb == r) ||
               (s.uc && s.rc == r) || (s.w && s.rt == r);
    endfunction

    vec_t tbl [10];

    initial begin
        // Pair-rule vectors, each applied from a freshly reset state.
        tbl[0] = mv(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0), idle(), 0, 0, 1, 0, 0);
        tbl[1] = mv(mk(1, 1, 0, 2, 0, 0, 0, 10, 1, 2),
                    mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0), 0, 0, 1, 0, 1);
        tbl[2] = mv(mk(1, 0, 0, 0, 0, 0, 0, 9, 1, 1),
                    mk(1, 0, 0, 0, 0, 0, 0, 9, 1, 1), 0, 0, 1, 0, 1);
        tbl[3] = mv(mk(1, 0, 0, 0, 0, 0, 0, 9, 1, 1),
                    mk(1, 9, 0, 1, 1, 2, 1, 11, 1, 1), 0, 0, 1, 1, 0);
        tbl[4] = mv(mk(0, 0, 0, 0, 0, 0, 0, 9, 1, 1),
                    mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0);
        tbl[5] = mv(idle(), idle(), 0, 0, 0, 0, 0);
        tbl[6] = mv(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0),
                    mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 1);
        tbl[7] = mv(mk(1, 0, 0, 0, 0, 0, 0, 4, 1, 3),
                    mk(1, 0, 0, 0, 0, 6, 1, 5, 1, 3), 0, 0, 1, 1, 0);
        tbl[8] = mv(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2),
                    mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 1, 0, 1);
        tbl[9] = mv(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0),
                    mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0);

        drive(idle(), idle(), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        // Grants stay low while reset is asserted, even with valid inputs.
        drive(mk(1, 1, 1, 2, 1, 0, 0, 3, 1, 2), mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0),
              1'b0, 1'b1);
        expect_cyc("in_reset", 1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            drive(tbl[i].s1, tbl[i].s2, tbl[i].f, tbl[i].r);
            expect_cyc($sformatf("tbl%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].es, '0);
        end

        // Latency 3 on r5: dependent is held for three cycles.
        do_reset();
        drive(mk(1, 1, 1, 2, 1, 0, 0, 5, 1, 3), idle(), 1'b0, 1'b0);
        expect_cyc("lat3_c0", 1'b1, 1'b0, 1'b0, '0);
        drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0), idle(), 1'b0, 1'b0);
        expect_cyc("lat3_c1", 1'b0, 1'b0, 1'b1, bit_of(5));
        expect_cyc("lat3_c2", 1'b0, 1'b0, 1'b1, bit_of(5));
        expect_cyc("lat3_c3", 1'b0, 1'b0, 1'b1, bit_of(5));
        expect_cyc("lat3_c4", 1'b1, 1'b0, 1'b0, '0);

        // Intra-pair RAW on r10, then the younger instruction re-presented.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 10, 1, 2), mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0),
              1'b0, 1'b0);
        expect_cyc("pair_c0", 1'b1, 1'b0, 1'b1, '0);
        drive(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0), idle(), 1'b0, 1'b0);
        expect_cyc("pair_c1", 1'b0, 1'b0, 1'b1, bit_of(10));
        expect_cyc("pair_c2", 1'b0, 1'b0, 1'b1, bit_of(10));
        expect_cyc("pair_c3", 1'b1, 1'b0, 1'b0, '0);

        // In-order: a held slot 1 blocks an independent slot 2.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 7, 1, 4), idle(), 1'b0, 1'b0);
        expect_cyc("order_c0", 1'b1, 1'b0, 1'b0, '0);
        drive(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0), mk(1, 8, 1, 0, 0, 0, 0, 12, 1, 1),
              1'b0, 1'b0);
        expect_cyc("order_c1", 1'b0, 1'b0, 1'b1, bit_of(7));
        drive(idle(), mk(1, 8, 1, 0, 0, 0, 0, 12, 1, 1), 1'b0, 1'b0);
        expect_cyc("order_c2", 1'b0, 1'b1, 1'b0, bit_of(7));

        // Flush discards a long pending write and loads nothing new.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 20, 1, 6), idle(), 1'b0, 1'b0);
        expect_cyc("flush_c0", 1'b1, 1'b0, 1'b0, '0);
        drive(mk(1, 20, 1, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 30, 1, 2),
              1'b1, 1'b0);
        expect_cyc("flush_c1", 1'b0, 1'b0, 1'b1, bit_of(20));
        drive(mk(1, 20, 1, 0, 0, 0, 0, 0, 0, 0), idle(), 1'b0, 1'b0);
        expect_cyc("flush_c2", 1'b1, 1'b0, 1'b0, '0);

        // Latency 0 behaves as 1.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0), idle(), 1'b0, 1'b0);
        expect_cyc("lat0_c0", 1'b1, 1'b0, 1'b0, '0);
        drive(idle(), idle(), 1'b0, 1'b0);
        expect_cyc("lat0_c1", 1'b0, 1'b0, 1'b0, bit_of(3));
        expect_cyc("lat0_c2", 1'b0, 1'b0, 1'b0, '0);

        // Randomized run against the release-time model.
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) until_c[i] = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            slot_t               a;
            slot_t               b;
            logic                f;
            logic                r;
            logic [NUM_REGS-1:0] mb;
            logic                e1;
            logic                e2;
            logic                es;
            logic                intra;
            a = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7));
            b = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7));
            f = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 59) == 0);
            drive(a, b, f, r);

            mb = '0;
            for (int k = 0; k < NUM_REGS; k++) mb[k] = (cyc <= until_c[k]);
            intra = a.v && a.w && touches(b, a.rt);
            e1 = a.v && !src_hazard(a, mb) && !f && !r;
            e2 = b.v && !src_hazard(b, mb) && !intra && !f && !r && (e1 || !a.v);
            es = !r && ((a.v && !e1) || (b.v && !e2));

            @(negedge clk);
            check1($sformatf("rnd%0d_issue1", cyc), issue1, e1);
            check1($sformatf("rnd%0d_issue2", cyc), issue2, e2);
            check1($sformatf("rnd%0d_stall", cyc),  stall,  es);
            checkv($sformatf("rnd%0d_busy", cyc),   busy,   mb);

            if (r || f) begin
                for (int k = 0; k < NUM_REGS; k++) until_c[k] = -1;
            end else begin
                if (e1 && a.w) until_c[a.rt] = cyc + ((a.lat == 0) ? 1 : int'(a.lat));
                if (e2 && b.w) until_c[b.rt] = cyc + ((b.lat == 0) ? 1 : int'(b.lat));
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
- Issue-control scoreboard for the 128-entry, 128-bit dual-read-port-pair register file.
- Sits between decode and register fetch. Decides each cycle whether the two candidate instructions may read operands and issue. Slot 1 is the older instruction; slot 2 is the younger.
- Tracks outstanding writes per register with latency countdowns. Blocks RAW and WAW hazards, including hazards between the two slots of one pair.
- Preserves in-order issue.

Parameters:
- NUM_REGS, 128, number of architectural registers tracked.
- ADDR_W, 7, register address width.
- LAT_W, 3, width of the latency field and the per-register countdown.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  synchronous clear of all pending-write state
- valid1  in  1  slot 1 instruction present
- ra1, rb1, rc1  in  ADDR_W each  slot 1 source addresses
- use_ra1, use_rb1, use_rc1  in  1 each  slot 1 source is actually read
- rt1  in  ADDR_W  slot 1 destination address
- wr_rt1  in  1  slot 1 writes rt1
- lat1  in  LAT_W  slot 1 result latency in cycles
- valid2, ra2, rb2, rc2, use_ra2, use_rb2, use_rc2, rt2, wr_rt2, lat2  in  as slot 1  slot 2 equivalents
- issue1  out  1  slot 1 issues this cycle
- issue2  out  1  slot 2 issues this cycle
- stall  out  1  a valid instruction was held this cycle
- busy  out  NUM_REGS  bit i set when register i has a pending write

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- State: cnt[i] of LAT_W bits for each register. busy[i] = (cnt[i] != 0).
- Reset: all cnt = 0, so busy = 0. issue1, issue2 and stall are combinational and evaluate to 0 while reset is high.
- Grants are combinational from current state and inputs (same-cycle decision). State updates on the clk edge.
- hz1 (slot 1 hazard) is true if any of the following holds:
  - (use_ra1 & busy[ra1]), (use_rb1 & busy[rb1]) or (use_rc1 & busy[rc1]).
  - (wr_rt1 & busy[rt1]), a WAW hazard.
- issue1 = valid1 & ~hz1 & ~flush & ~reset.
- hz2 (slot 2 hazard) is the same checks as hz1 using slot 2 fields, plus an intra-pair hazard: valid1 & wr_rt1 & slot 2 either reads rt1 on any used source, or has wr_rt2 with rt2 == rt1.
- Ordering:
  - issue2 = valid2 & ~hz2 & ~flush & ~reset & (issue1 | ~valid1).
  - Slot 2 never issues ahead of a held slot 1.
  - When issue1=1 and issue2=0, slot 2 is re-presented by decode (it becomes the next slot 1). This block holds no instruction state.
- stall = (valid1 & ~issue1) | (valid2 & ~issue2), forced to 0 during reset.
- Countdown per register, evaluated at each clk edge:
  - reset or flush: cnt = 0 for all registers.
  - Else, if issue1 & wr_rt1 & i==rt1: cnt[i] = max(lat1, 1).
  - Else, if issue2 & wr_rt2 & i==rt2: cnt[i] = max(lat2, 1).
  - Else, if cnt[i] != 0: cnt[i] = cnt[i] - 1.
- The WAW check guarantees that a newly issued write never targets a register with a nonzero count. The intra-pair check guarantees that slot 1 and slot 2 never load the same register in one cycle.
- Latency semantics:
  - An instruction issued at cycle T with lat L sets busy for cycles T+1 through T+L.
  - A dependent instruction may issue at cycle T+L+1 at the earliest.
  - lat = 0 is treated as 1.
  - The maximum latency is 7 and the counter never wraps.
- Write-back ordering: the scoreboard does not arbitrate write ports. Two pipes may retire in the same cycle because their destinations are guaranteed distinct.
- Register 0 receives no special treatment.
- Flush mid-operation: at the next edge all busy bits clear, regardless of remaining count. Grants in the flush cycle are 0. No cnt is loaded in the flush cycle.

Test Plan:
- Reset, then valid1=1 with sources r1, r2, no busy registers, valid2=0 -> issue1=1, issue2=0, stall=0, busy=0.
- Cycle 0: issue wr_rt1 rt1=5 lat1=3. Cycles 1-4: valid1=1 reading ra1=5 -> busy[5]=1 in cycles 1-3; issue1=0 and stall=1 in cycles 1-3; issue1=1 in cycle 4.
- Pair with slot 1 writing r10 (lat 2) and slot 2 reading rb2=10 -> issue1=1, issue2=0, stall=1. Re-presenting the slot 2 instruction as slot 1 in the following cycles -> issue1=0 until busy[10] clears.
- Slot 1 reads busy r7 while slot 2 is independent -> issue1=0 and issue2=0 (in-order). valid1=0 with slot 2 independent -> issue2=1.
- With busy[20] pending (cnt=6), assert flush for one cycle -> grants are 0 in the flush cycle. Next cycle busy=0, and an instruction reading r20 issues.
- wr_rt1 with rt1=3 lat1=0 -> busy[3]=1 for exactly one cycle. Pair with slot 1 and slot 2 both writing r9 -> issue1=1, issue2=0.
